// File: rtl/seq101_pkg.sv
// Shared definitions for the "101" sync link (transmitter and receiver-side detector).
package seq101_pkg;

    // Transmitter line states; each state names what is on the line this cycle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE0,
        ST_PRE1,
        ST_PRE2,
        ST_DATA,
        ST_STUFF,
        ST_GAP
    } state_e;

    localparam logic [2:0]  SYNC_PATTERN = 3'b101;
    localparam int unsigned MIN_GAP      = 2;

endpackage

// File: rtl/seq101_frame_tx_if.sv
// Parallel payload handshake into the frame transmitter.
interface seq101_frame_tx_if #(
    parameter int unsigned W = 8
) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/seq101_frame_tx.sv
// Serial frame transmitter: "101" preamble, zero-stuffed MSB-first payload, idle gap.
// Stuffing after every in-payload "10" plus the gap keeps "101" unique to the preamble.
module seq101_frame_tx
    import seq101_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    seq101_frame_tx_if.slave bus,
    output logic             out,
    output logic             out_frame,
    output logic             frame_done
);

    localparam int unsigned IDX_W = $clog2(W + 1);
    localparam int unsigned GAP_W = $clog2(GAP + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    // A shorter gap would let a trailing "10" plus the next preamble form a false "101".
    if (GAP < MIN_GAP) begin : g_gap_check
        $error("seq101_frame_tx: GAP must be at least %0d", MIN_GAP);
    end

    state_e           r_state;
    logic [W-1:0]     r_shreg;
    logic [1:0]       r_hist;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_out;
    logic             r_frame;
    logic             r_done;

    logic             w_accept;
    logic             w_bit;
    logic             w_stuff;
    logic             w_last;

    assign bus.in_ready = (r_state == ST_IDLE) & ~rst;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_bit        = r_shreg[W-1];
    // r_hist/r_idx already include the bit currently on the line.
    assign w_stuff      = (r_state == ST_DATA) && (r_hist == 2'b10) && (r_idx < IDX_LAST);
    assign w_last       = (r_state == ST_DATA) && (r_idx == IDX_LAST);

    assign out        = r_out;
    assign out_frame  = r_frame;
    assign frame_done = r_done;

    // Frame FSM: state and registered line outputs are updated together for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_hist    <= 2'b00;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_out     <= 1'b0;
            r_frame   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg <= bus.in_data;
                        r_idx   <= '0;
                        r_state <= ST_PRE0;
                        r_out   <= 1'b1;
                        r_frame <= 1'b1;
                    end
                end
                ST_PRE0: begin
                    r_state <= ST_PRE1;
                    r_out   <= 1'b0;
                end
                ST_PRE1: begin
                    r_state <= ST_PRE2;
                    r_out   <= 1'b1;
                    // Preamble tail "01" seeds the history so a leading 0 payload bit stuffs.
                    r_hist  <= 2'b01;
                end
                ST_PRE2, ST_STUFF, ST_DATA: begin
                    if (w_stuff) begin
                        r_state <= ST_STUFF;
                        r_out   <= 1'b0;
                        r_hist  <= 2'b00;
                    end else if (w_last) begin
                        // A final "10" is not stuffed; the gap zeros break it instead.
                        r_state   <= ST_GAP;
                        r_out     <= 1'b0;
                        r_frame   <= 1'b0;
                        r_done    <= 1'b1;
                        r_gap_cnt <= GAP_ONE;
                    end else begin
                        r_state <= ST_DATA;
                        r_out   <= w_bit;
                        r_hist  <= {r_hist[0], w_bit};
                        r_shreg <= r_shreg << 1;
                        r_idx   <= r_idx + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b0;
                    r_frame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq101_frame_tx.sv
// Self-checking bench for seq101_frame_tx: per-cycle line scoreboard plus a "101" detector.
module tb_seq101_frame_tx;
    import seq101_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned GAP = 2;

    // Expected line state per cycle; s marks the cycle a "101" detector must fire.
    typedef struct packed {
        logic o;
        logic f;
        logic d;
        logic s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       out_w;
    logic       frame_w;
    logic       done_w;
    logic [2:0] line_q = 3'b000;
    logic       det;
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    seq101_frame_tx_if #(.W(W)) bus ();

    seq101_frame_tx #(
        .W   (W),
        .GAP (GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .out        (out_w),
        .out_frame  (frame_w),
        .frame_done (done_w)
    );

    always #5 clk = ~clk;

    // Far-end overlapping Moore detector on the line.
    always @(posedge clk) line_q <= {line_q[1:0], out_w};
    assign det = ({line_q[1:0], out_w} == SYNC_PATTERN);

    // Push n frame bits (MSB of the n first) followed by the gap cycles.
    function automatic void push_line(input logic [31:0] v, input int n);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e   = '0;
            e.o = v[i];
            e.f = 1'b1;
            e.s = (i == n - 3);
            exp_q.push_back(e);
        end
        for (int g = 0; g < GAP; g++) begin
            e   = '0;
            e.d = (g == 0);
            exp_q.push_back(e);
        end
    endfunction

    // Reference framing: preamble, MSB-first payload, zero after any non-final "10".
    function automatic void push_model(input logic [7:0] d);
        logic [31:0] v;
        int          n;
        logic [1:0]  h;
        v = 32'b101;
        n = 3;
        h = 2'b01;
        for (int i = W - 1; i >= 0; i--) begin
            v = {v[30:0], d[i]};
            n++;
            h = {h[0], d[i]};
            if (h == 2'b10 && i != 0) begin
                v = {v[30:0], 1'b0};
                n++;
                h = 2'b00;
            end
        end
        push_line(v, n);
    endfunction

    // Offer d and return at the negedge of the first frame cycle; in_valid is left high.
    task automatic send(input logic [7:0] d, output bit ok);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        @(negedge clk);
        checks++;
        if ({out_w, frame_w, done_w} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: out/frame/done=%b%b%b expected 000",
                     out_w, frame_w, done_w);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: in_ready=%b expected 0", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || out_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out=%b expected 1 0", bus.in_ready, out_w);
        end
    endtask

    task automatic test_single();
        logic [31:0] vecs [3];
        int          lens [3];
        logic [7:0]  dats [3];
        exp_t        e;
        bit          ok;
        int          cyc;
        vecs = '{32'b10110010001001, 32'b101000000000, 32'b10111111111};
        lens = '{14, 12, 11};
        dats = '{8'hA5, 8'h00, 8'hFF};
        for (int k = 0; k < 3; k++) begin
            push_line(vecs[k], lens[k]);
            send(dats[k], ok);
            bus.in_valid = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL single_accept: data=%h in_ready never high", dats[k]);
                exp_q.delete();
            end
            cyc = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({out_w, frame_w, done_w} !== {e.o, e.f, e.d}) begin
                    errors++;
                    $display("FAIL single data=%h cyc %0d: out/frame/done=%b%b%b expected %b%b%b",
                             dats[k], cyc + 1, out_w, frame_w, done_w, e.o, e.f, e.d);
                end
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL single_ready_after_gap data=%h: in_ready=%b expected 1",
                         dats[k], bus.in_ready);
            end
        end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        bit   ok;
        int   cyc;
        push_line(32'b10110010001001, 14);
        send(8'hA5, ok);
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_accept: in_ready never high");
            exp_q.delete();
        end
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_w, frame_w, done_w} !== {e.o, e.f, e.d}) begin
                errors++;
                $display("FAIL busy cyc %0d: out/frame/done=%b%b%b expected %b%b%b",
                         cyc + 1, out_w, frame_w, done_w, e.o, e.f, e.d);
            end
            bus.in_valid = (cyc == 4 || cyc == 9);
            bus.in_data  = 8'h3C;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_w !== 1'b0 || frame_w !== 1'b0) begin
                errors++;
                $display("FAIL busy_no_extra_frame idle %0d: out=%b frame=%b expected 0 0",
                         i, out_w, frame_w);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        bit   ok;
        int   cyc;
        push_line(32'b10110010001001, 14);
        send(8'hA5, ok);
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_accept: in_ready never high");
            exp_q.delete();
        end
        // Stop on line cycle 7, a payload bit following the first stuff.
        for (cyc = 0; cyc < 6 && exp_q.size() > 0; cyc++) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_w, frame_w} !== {e.o, e.f}) begin
                errors++;
                $display("FAIL rstmid_pre cyc %0d: out/frame=%b%b expected %b%b",
                         cyc + 1, out_w, frame_w, e.o, e.f);
            end
            @(negedge clk);
        end
        exp_q.delete();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready_during_rst: in_ready=%b expected 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if ({out_w, frame_w, done_w} !== 3'b000 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after_edge: out/frame/done/ready=%b%b%b%b expected 0000",
                     out_w, frame_w, done_w, bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready_after: in_ready=%b expected 1", bus.in_ready);
        end
        push_line(32'b10111111111, 11);
        send(8'hFF, ok);
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_ff_accept: in_ready never high");
            exp_q.delete();
        end
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({out_w, frame_w, done_w} !== {e.o, e.f, e.d}) begin
                errors++;
                $display("FAIL rstmid_ff cyc %0d: out/frame/done=%b%b%b expected %b%b%b",
                         cyc + 1, out_w, frame_w, done_w, e.o, e.f, e.d);
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        bit         ok;
        int         frames;
        int         dets;
        int         cyc;
        logic [7:0] d;
        frames = 0;
        dets   = 0;
        for (int f = 0; f < 1000; f++) begin
            d = 8'($urandom);
            push_model(d);
            send(d, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL b2b_accept frame %0d: in_ready never high", f);
                exp_q.delete();
                break;
            end
            frames++;
            cyc = 0;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (det === 1'b1) dets++;
                checks++;
                if ({out_w, frame_w, done_w, det} !== {e.o, e.f, e.d, e.s}) begin
                    errors++;
                    $display("FAIL b2b frame %0d data=%h cyc %0d: out/frame/done/det=%b%b%b%b %s%b%b%b%b",
                             f, d, cyc + 1, out_w, frame_w, done_w, det,
                             "expected ", e.o, e.f, e.d, e.s);
                end
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (bus.in_ready !== 1'b1 || det !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle frame %0d: in_ready=%b det=%b expected 1 0",
                         f, bus.in_ready, det);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (dets != frames) begin
            errors++;
            $display("FAIL b2b_detect_count: detects=%0d expected %0d", dets, frames);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
